// File: rtl/bus_pkg.sv
// Shared types and constants for the bus master interface slice.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam int ADDR_W_DEF  = 30;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;
    localparam int CNT_W       = 10;

endpackage

// File: rtl/bus_master_if_if.sv
// External bus signal bundle; master drives strobes/attributes, slave answers.
interface bus_master_if_if
    import bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              bus_req_n;
    logic              bus_as_n;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic              bus_grnt_n;
    logic              bus_rdy_n;
    logic [DATA_W-1:0] bus_rd_data;

    modport master (
        output bus_req_n, bus_as_n, bus_rw, bus_addr, bus_wr_data,
        input  bus_grnt_n, bus_rdy_n, bus_rd_data
    );

    modport slave (
        input  bus_req_n, bus_as_n, bus_rw, bus_addr, bus_wr_data,
        output bus_grnt_n, bus_rdy_n, bus_rd_data
    );

endinterface

// File: rtl/bus_timeout_cnt.sv
// Wait-cycle counter; expired flags the cycle whose increment reaches TIMEOUT.
module bus_timeout_cnt
    import bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/bus_master_if.sv
// CPU-side request to external request/grant/strobe/ready bus master.
module bus_master_if
    import bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    bus_master_if_if.master   bus
);

    state_t state, state_nxt;

    logic              expired;
    logic              rdy;
    logic              req_n_nxt;
    logic              as_n_nxt;
    logic              rw_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wd_nxt;
    logic [DATA_W-1:0] rd_nxt;
    logic              done_nxt;
    logic              err_nxt;

    assign rdy = (bus.bus_rdy_n == ENABLE_);

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ACCESS),
        .enable  ((state == WAIT) && !rdy),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cpu_req) state_nxt = REQ;
            REQ:     if (bus.bus_grnt_n == ENABLE_) state_nxt = ACCESS;
            ACCESS:  state_nxt = WAIT;
            WAIT:    if (rdy || expired) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready beats timeout when both land on the same cycle.
    always_comb begin
        req_n_nxt = bus.bus_req_n;
        as_n_nxt  = DISABLE_;
        rw_nxt    = bus.bus_rw;
        addr_nxt  = bus.bus_addr;
        wd_nxt    = bus.bus_wr_data;
        rd_nxt    = cpu_rd_data;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    req_n_nxt = ENABLE_;
                    rw_nxt    = cpu_rw;
                    addr_nxt  = cpu_addr;
                    wd_nxt    = cpu_wr_data;
                end
            end
            REQ: begin
                if (bus.bus_grnt_n == ENABLE_) as_n_nxt = ENABLE_;
            end
            ACCESS: ;
            WAIT: begin
                if (rdy) begin
                    done_nxt  = 1'b1;
                    req_n_nxt = DISABLE_;
                    if (bus.bus_rw == READ) rd_nxt = bus.bus_rd_data;
                end else if (expired) begin
                    err_nxt   = 1'b1;
                    req_n_nxt = DISABLE_;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.bus_req_n   <= DISABLE_;
            bus.bus_as_n    <= DISABLE_;
            bus.bus_rw      <= READ;
            bus.bus_addr    <= '0;
            bus.bus_wr_data <= '0;
            cpu_rd_data     <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            bus.bus_req_n   <= req_n_nxt;
            bus.bus_as_n    <= as_n_nxt;
            bus.bus_rw      <= rw_nxt;
            bus.bus_addr    <= addr_nxt;
            bus.bus_wr_data <= wd_nxt;
            cpu_rd_data     <= rd_nxt;
            busy            <= (state_nxt != IDLE);
            done            <= done_nxt;
            err             <= err_nxt;
        end
    end

endmodule
